msrv32_fetch_buffer: RTL

- Instruction-fetch front end that issues sequential word fetches to instruction memory and holds the returned words, with their PCs, in a small in-order FIFO.
- Presents the FIFO head to the instruction mux as instr_out/flush_out. flush_out tells the mux to substitute a NOP (0x00000013) whenever no valid instruction is available or a redirect is in progress.
- On a branch/trap redirect it clears the FIFO, discards in-flight memory responses and restarts fetch at the new PC.

---
 rtl/msrv32_fetch_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/msrv32_fetch_buffer.sv
// Sequential instruction fetch with an in-order response FIFO and redirect handling.
// Optional bubble counter output is enabled by defining MSRV32_FETCH_PERF_EN.
module msrv32_fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        flush_out
`ifdef MSRV32_FETCH_PERF_EN
    ,
    output logic [31:0] bubble_cnt_out
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [CW:0]   in_use;
    logic [31:0]   target_pc;
    logic          accept;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          has_entry;

    // In-flight fetches plus buffered words never exceed DEPTH, so a push always has a free slot.
    assign in_use    = {1'b0, outstanding} + {1'b0, count};
    assign target_pc = redirect_pc_in & ~32'h3;
    assign has_entry = (count != '0);

    assign imem_req_out  = !rst_in && !redirect_in && (in_use < DEPTH_C);
    assign imem_addr_out = fetch_pc;

    assign accept = imem_req_out && imem_gnt_in;
    assign rsp_ok = imem_rvalid_in && (outstanding != '0);
    assign push   = rsp_ok && (drop == '0) && !redirect_in;
    assign pop    = instr_valid_out && !stall_in;

    assign instr_valid_out = has_entry && !redirect_in;
    assign flush_out       = !has_entry || redirect_in;
    assign instr_out       = has_entry ? instr_mem[rd_ptr] : NOP;
    assign pc_out          = has_entry ? pc_mem[rd_ptr] : resp_pc;

    always_comb begin
        outstanding_next = outstanding;
        case ({accept, rsp_ok})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_in) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_ok) begin
                    if (drop != '0) begin
                        drop <= drop - 1'b1;
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk_in) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata_in;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

`ifdef MSRV32_FETCH_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bubble_cnt_out <= '0;
        end else if (!instr_valid_out && !stall_in && (bubble_cnt_out != 32'hFFFF_FFFF)) begin
            bubble_cnt_out <= bubble_cnt_out + 32'd1;
        end
    end
`endif

endmodule
